// File: rtl/npn_tt_sweeper_pkg.sv
// Shared types for the NPN truth-table sweeper: FSM states, vector counts, index type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package npn_sweep_pkg;

    localparam int NUM_VARS = 4;
    localparam int NUM_VEC  = 16;

    typedef logic [3:0] vec_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/npn_tt_sweeper_if.sv
// Signal bundle between the sweeper, its controller and the netlist under test.
// Latency: n/a (wires only).
// Backpressure: none; start is a single-cycle request, done is a level.
// master: sweeper side (drives x0..x3 and results, consumes start and y0).
// slave : harness side (drives start and y0, consumes stimulus and results).
interface npn_tt_sweeper_if;
    import npn_sweep_pkg::*;

    logic        start;
    logic        x0;
    logic        x1;
    logic        x2;
    logic        x3;
    logic        y0;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic        match;
    vec_idx_t    fail_idx;

    modport master (
        input  start, y0,
        output x0, x1, x2, x3, busy, done, tt, match, fail_idx
    );

    modport slave (
        output start, y0,
        input  x0, x1, x2, x3, busy, done, tt, match, fail_idx
    );

endinterface

// File: rtl/npn_tt_sweeper_netlist.sv
// Synthesized 4-input NPN netlist for truth table 16'hE61E (x0..x3 -> y0).
// Latency: purely combinational.
// Backpressure: none.
// Ports: x0..x3 inputs, y0 output.
module top (
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    output logic y0
);
    logic n_or;
    logic n_xor;
    logic n_lo;
    logic n_hi;

    assign n_or  = x0 | x1;
    assign n_xor = x0 ^ x1;
    // Lower half (x3=0): OR, inverted when x2 is set.
    assign n_lo  = x2 ^ n_or;
    // Upper half (x3=1): XOR when x2=0, OR when x2=1.
    assign n_hi  = x2 ? n_or : n_xor;
    assign y0    = x3 ? n_hi : n_lo;
endmodule

// File: rtl/npn_tt_sweeper.sv
// Walks all 16 input vectors through a combinational netlist and harvests/checks its truth table.
// Latency: done 16*(SETTLE+1) cycles after the accepting start edge.
// Backpressure: none; start while busy is ignored, start in IDLE/DONE restarts immediately.
// Ports: clk, rst (async high); start in; x0..x3 out to netlist; y0 in from netlist;
//        busy, done (level), tt[15:0], match, fail_idx[3:0] out.
module npn_tt_sweeper
    import npn_sweep_pkg::*;
#(
    parameter logic [15:0] EXPECTED_TT = 16'hE61E,
    parameter int          SETTLE      = 1          // must be >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x0,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    input  logic       y0,
    output logic       busy,
    output logic       done,
    output logic [15:0] tt,
    output logic       match,
    output vec_idx_t   fail_idx
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam vec_idx_t         LAST_IDX    = vec_idx_t'(NUM_VEC - 1);

    sweep_state_t          state_q, state_d;
    vec_idx_t              idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_VARS-1:0]   x_q, x_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [NUM_VEC-1:0]    tt_q, tt_d;
    logic                  match_q, match_d;
    vec_idx_t              fail_idx_q, fail_idx_d;
    logic                  fail_seen_q, fail_seen_d;
    logic                  mismatch;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        busy_d      = busy_q;
        done_d      = done_q;
        tt_d        = tt_q;
        match_d     = match_q;
        fail_idx_d  = fail_idx_q;
        fail_seen_d = fail_seen_q;
        mismatch    = (y0 != EXPECTED_TT[idx_q]);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = DRIVE;
                    idx_d       = '0;
                    cnt_d       = '0;
                    x_d         = '0;
                    tt_d        = '0;
                    fail_idx_d  = '0;
                    fail_seen_d = 1'b0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end

            DRIVE: begin
                // Counter restarts at 0 for every vector, so SETTLE cycles elapse here.
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            SAMPLE: begin
                tt_d[idx_q] = y0;
                if (mismatch && !fail_seen_q) begin
                    fail_idx_d  = idx_q;
                    fail_seen_d = 1'b1;
                end
                // Last-vector test comes before the increment, so idx never wraps
                // and x stays parked at the final vector while DONE.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    match_d = !(fail_seen_q || mismatch);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    x_d     = idx_q + 4'd1;
                    state_d = DRIVE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tt_q        <= '0;
            match_q     <= 1'b0;
            fail_idx_q  <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tt_q        <= tt_d;
            match_q     <= match_d;
            fail_idx_q  <= fail_idx_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    assign {x3, x2, x1, x0} = x_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt       = tt_q;
    assign match    = match_q;
    assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_npn_tt_sweeper.sv
module tb_npn_tt_sweeper;
    import npn_sweep_pkg::*;

    typedef struct packed {
        logic [15:0] tt;
        logic        match;
        logic [3:0]  fail_idx;
        logic [31:0] cycles;
    } exp_t;

    localparam logic [15:0] DEF_TT = 16'hE61E;
    localparam logic [15:0] NET_TT = 16'hE61E;

    logic clk;
    logic rst;
    logic stub_zero;
    logic [3:0] start_v;
    int checks;
    int failures;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    npn_tt_sweeper_if if_a();
    npn_tt_sweeper_if if_b();
    npn_tt_sweeper_if if_c();
    npn_tt_sweeper_if if_d();

    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_d.start = start_v[3];

    // Netlist stand-ins
    assign if_a.y0 = if_a.x0;
    assign if_b.y0 = stub_zero ? 1'b0 : if_b.x0;
    assign if_c.y0 = if_c.x3;

    top u_net (.x0(if_d.x0), .x1(if_d.x1), .x2(if_d.x2), .x3(if_d.x3), .y0(if_d.y0));

    npn_tt_sweeper #(.EXPECTED_TT(16'hAAAA), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(if_a.start),
        .x0(if_a.x0), .x1(if_a.x1), .x2(if_a.x2), .x3(if_a.x3), .y0(if_a.y0),
        .busy(if_a.busy), .done(if_a.done), .tt(if_a.tt), .match(if_a.match), .fail_idx(if_a.fail_idx));

    npn_tt_sweeper u_b (
        .clk(clk), .rst(rst), .start(if_b.start),
        .x0(if_b.x0), .x1(if_b.x1), .x2(if_b.x2), .x3(if_b.x3), .y0(if_b.y0),
        .busy(if_b.busy), .done(if_b.done), .tt(if_b.tt), .match(if_b.match), .fail_idx(if_b.fail_idx));

    npn_tt_sweeper #(.SETTLE(3)) u_c (
        .clk(clk), .rst(rst), .start(if_c.start),
        .x0(if_c.x0), .x1(if_c.x1), .x2(if_c.x2), .x3(if_c.x3), .y0(if_c.y0),
        .busy(if_c.busy), .done(if_c.done), .tt(if_c.tt), .match(if_c.match), .fail_idx(if_c.fail_idx));

    npn_tt_sweeper u_d (
        .clk(clk), .rst(rst), .start(if_d.start),
        .x0(if_d.x0), .x1(if_d.x1), .x2(if_d.x2), .x3(if_d.x3), .y0(if_d.y0),
        .busy(if_d.busy), .done(if_d.done), .tt(if_d.tt), .match(if_d.match), .fail_idx(if_d.fail_idx));

    wire [3:0] done_v  = {if_d.done,  if_c.done,  if_b.done,  if_a.done};
    wire [3:0] busy_v  = {if_d.busy,  if_c.busy,  if_b.busy,  if_a.busy};
    wire [3:0] match_v = {if_d.match, if_c.match, if_b.match, if_a.match};
    logic [15:0] tt_v   [4];
    logic [3:0]  fail_v [4];
    logic [3:0]  x_v    [4];
    assign tt_v[0] = if_a.tt;  assign tt_v[1] = if_b.tt;  assign tt_v[2] = if_c.tt;  assign tt_v[3] = if_d.tt;
    assign fail_v[0] = if_a.fail_idx; assign fail_v[1] = if_b.fail_idx;
    assign fail_v[2] = if_c.fail_idx; assign fail_v[3] = if_d.fail_idx;
    assign x_v[0] = {if_a.x3, if_a.x2, if_a.x1, if_a.x0};
    assign x_v[1] = {if_b.x3, if_b.x2, if_b.x1, if_b.x0};
    assign x_v[2] = {if_c.x3, if_c.x2, if_c.x1, if_c.x0};
    assign x_v[3] = {if_d.x3, if_d.x2, if_d.x1, if_d.x0};

    // Reference: stub 0 = x0, 1 = constant 0, 2 = x3, 3 = real netlist.
    function automatic exp_t model(input int stub, input logic [15:0] exp_tt, input int settle);
        exp_t e;
        logic found;
        logic [3:0] v;
        found      = 1'b0;
        e.tt       = '0;
        e.fail_idx = '0;
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            case (stub)
                0:       e.tt[i] = v[0];
                1:       e.tt[i] = 1'b0;
                2:       e.tt[i] = v[3];
                default: e.tt[i] = NET_TT[i];
            endcase
            if (!found && (e.tt[i] !== exp_tt[i])) begin
                found      = 1'b1;
                e.fail_idx = v;
            end
        end
        e.match  = (e.tt == exp_tt);
        e.cycles = 32'(16 * (settle + 1));
        return e;
    endfunction

    task automatic pulse_start(input int which);
        @(negedge clk);
        start_v[which] = 1'b1;
        @(posedge clk);
        #1;
        start_v[which] = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (or budget runs out).
    task automatic wait_done(input int which, input int budget, output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b1;
        while (timed_out && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done_v[which]) timed_out = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [25:0] obs;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        for (int w = 0; w < 4; w++) begin
            obs = {x_v[w], busy_v[w], done_v[w], tt_v[w], match_v[w], fail_v[w]};
            checks++;
            if (obs !== 26'd0) begin
                failures++;
                $display("FAIL reset_state inst=%0d got=%h want=0", w, obs);
            end
        end
        // start held through the reset release edge must not launch a sweep
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL start_during_reset busy=%b done=%b want 0/0", busy_v[0], done_v[0]);
        end
    endtask

    task automatic check_result(input int which, input string name, input int cycles, input bit to);
        exp_t e;
        checks++;
        if (to || sb.size() == 0) begin
            failures++;
            $display("FAIL %s timeout_or_empty_sb cycles=%0d sb=%0d", name, cycles, sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (cycles !== int'(e.cycles)) begin
            failures++;
            $display("FAIL %s done_latency got=%0d want=%0d", name, cycles, e.cycles);
        end
        checks++;
        if (tt_v[which] !== e.tt) begin
            failures++;
            $display("FAIL %s tt got=%h want=%h", name, tt_v[which], e.tt);
        end
        checks++;
        if (match_v[which] !== e.match || busy_v[which] !== 1'b0) begin
            failures++;
            $display("FAIL %s match/busy got=%b/%b want=%b/0", name, match_v[which], busy_v[which], e.match);
        end
        if (!e.match) begin
            checks++;
            if (fail_v[which] !== e.fail_idx) begin
                failures++;
                $display("FAIL %s fail_idx got=%0d want=%0d", name, fail_v[which], e.fail_idx);
            end
        end
    endtask

    task automatic test_match();
        int cyc;
        bit to;
        sb.push_back(model(0, 16'hAAAA, 1));
        pulse_start(0);
        checks++;
        if (busy_v[0] !== 1'b1 || x_v[0] !== 4'h0) begin
            failures++;
            $display("FAIL first_vector busy=%b x=%h want 1/0", busy_v[0], x_v[0]);
        end
        wait_done(0, 100, cyc, to);
        check_result(0, "match_x0", cyc, to);
    endtask

    task automatic test_mismatch();
        int cyc;
        bit to;
        stub_zero = 1'b0;
        sb.push_back(model(0, DEF_TT, 1));
        pulse_start(1);
        wait_done(1, 100, cyc, to);
        check_result(1, "mismatch_x0", cyc, to);
    endtask

    task automatic test_x_walk();
        int k;
        bit seen;
        logic [3:0] x_exp;
        stub_zero = 1'b1;
        sb.push_back(model(1, DEF_TT, 1));
        pulse_start(1);
        k    = 0;
        seen = 1'b0;
        while (!seen && k <= 100) begin
            x_exp = (k >= 32) ? 4'hF : 4'(k / 2);
            checks++;
            if (x_v[1] !== x_exp) begin
                failures++;
                $display("FAIL x_walk cycle=%0d x=%h want=%h", k, x_v[1], x_exp);
            end
            if (done_v[1]) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        check_result(1, "zero_stub", k, !seen);
    endtask

    task automatic test_ignore_start();
        int cyc;
        bit to;
        sb.push_back(model(2, DEF_TT, 3));
        pulse_start(2);
        cyc = 0;
        to  = 1'b1;
        while (to && cyc < 200) begin
            start_v[2] = (cyc == 10);
            @(posedge clk);
            #1;
            cyc++;
            if (done_v[2]) to = 1'b0;
        end
        start_v[2] = 1'b0;
        check_result(2, "settle3_x3", cyc, to);
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit to;
        logic [25:0] obs;
        exp_t part;
        stub_zero = 1'b0;
        pulse_start(1);
        repeat (16) @(posedge clk);
        #1;
        // vectors 0..7 have been sampled by now
        part = model(0, DEF_TT, 1);
        checks++;
        if (tt_v[1] !== (part.tt & 16'h00FF)) begin
            failures++;
            $display("FAIL partial_tt got=%h want=%h", tt_v[1], part.tt & 16'h00FF);
        end
        rst = 1'b1;
        #1;
        obs = {x_v[1], busy_v[1], done_v[1], tt_v[1], match_v[1], fail_v[1]};
        checks++;
        if (obs !== 26'd0) begin
            failures++;
            $display("FAIL async_reset_mid got=%h want=0", obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back(model(0, DEF_TT, 1));
        pulse_start(1);
        wait_done(1, 100, cyc, to);
        check_result(1, "after_reset", cyc, to);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        sb.push_back(model(3, DEF_TT, 1));
        pulse_start(3);
        wait_done(3, 100, cyc, to);
        check_result(3, "netlist", cyc, to);
        sb.push_back(model(3, DEF_TT, 1));
        pulse_start(3);
        checks++;
        if (done_v[3] !== 1'b0 || busy_v[3] !== 1'b1) begin
            failures++;
            $display("FAIL restart_from_done done=%b busy=%b want 0/1", done_v[3], busy_v[3]);
        end
        wait_done(3, 100, cyc, to);
        check_result(3, "netlist_rerun", cyc, to);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        start_v   = 4'b0;
        stub_zero = 1'b0;
        rst       = 1'b0;
        test_reset();
        test_match();
        test_mismatch();
        test_x_walk();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npn_tt_sweeper.md
# npn_tt_sweeper

Sequential truth-table harvester for the 4-input single-output NPN exact-synthesis netlists (`x0..x3 -> y0`).
- Drives all 16 input vectors into the combinational netlist and samples `y0` for each.
- Assembles the 16-bit truth table and compares it against the function's expected truth table, reporting the lowest-index mismatch.
- Sits directly upstream (driving `x0..x3`) and downstream (consuming `y0`) of each synthesized netlist in the hardware self-check harness.

## Interface
Parameters:
- `EXPECTED_TT`, 16'hE61E, expected truth table; bit `i` is `y0` for `{x3,x2,x1,x0} = i`.
- `SETTLE`, 1, cycles each vector is held before sampling (>= 1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin sweep; accepted only in IDLE or DONE.
- `x0`, `x1`, `x2`, `x3`  out  1 each  registered drive to netlist inputs.
- `y0`  in  1  netlist output.
- `busy`  out  1  sweep in progress.
- `done`  out  1  level; sweep complete, results valid.
- `tt`  out  16  harvested truth table.
- `match`  out  1  `tt == EXPECTED_TT`; valid while `done`.
- `fail_idx`  out  4  lowest vector index with mismatch; valid while `done && !match`.

## Operation
Reset values (asynchronous, all outputs): `x0..x3` = 0, `busy` = 0, `done` = 0, `tt` = 0, `match` = 0, `fail_idx` = 0, state IDLE.

States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + `start`: go to DRIVE with these updates:
  - idx = 0, `{x3..x0}` = 0.
  - `tt` = 0, `fail_idx` = 0, fail_seen = 0.
  - `done` = 0, `busy` = 1.
- DRIVE: hold `x` for SETTLE cycles (settle counter, width `$clog2(SETTLE+1)`), then go to SAMPLE.
- SAMPLE: one cycle; at its closing edge:
  - `tt[idx] <= y0`.
  - If `y0 != EXPECTED_TT[idx]` and !fail_seen: `fail_idx <= idx`, fail_seen <= 1.
  - If idx == 15: go to DONE. `match <= !(fail_seen || current mismatch)`, `done <= 1`, `busy <= 0`.
  - Otherwise: idx <= idx+1, `{x3..x0} <= idx+1`, go to DRIVE.
- DONE: outputs held until the next accepted `start` or reset. `x` stays at 4'hF.

Rules and boundary conditions:
- `start` while busy is ignored (no restart, no error).
- idx is 4-bit. The idx == 15 check precedes any increment, so no wrap occurs.
- Reset mid-sweep: immediate return to IDLE. Partial `tt` is discarded (cleared to 0).
- `start` asserted in the same cycle reset deasserts: ignored. The first accepted `start` is the first edge with `rst` low.
- `y0` is only sampled in SAMPLE. Glitches during DRIVE are irrelevant by construction.

## Timing
- `start` is sampled at edge E0.
- `busy` = 1 and vector 0 is driven after E0.
- Vector `i` is driven from edge `E0 + i*(SETTLE+1)`.
- Vector `i` is sampled at edge `E0 + i*(SETTLE+1) + SETTLE + 1`.
- `done` rises, and `busy` falls, at edge `E0 + 16*(SETTLE+1)`. With SETTLE = 1 this is 32 cycles.
- `tt`, `match` and `fail_idx` are updated on the same edge as `done`, so they are valid on its first high cycle.
- Back-to-back sweeps: `start` during DONE restarts with no idle gap; `done` drops on the accepting edge.

## Structure
- Shared package `npn_sweep_pkg` holds:
  - state enum `sweep_state_t` (IDLE, DRIVE, SAMPLE, DONE);
  - `NUM_VARS` = 4 and `NUM_VEC` = 16;
  - the vector-index type `vec_idx_t` (logic [3:0]).
- No sub-module: a single FSM with idx and settle counters. The bench instantiates the sweeper alongside a netlist `top` instance, connected by name.

## Test plan
- Stub `y0 = x0`, `EXPECTED_TT = 16'hAAAA`, SETTLE = 1, pulse `start` -> `done` at +32 edges, `tt` = 16'hAAAA, `match` = 1.
- Stub `y0 = x0`, default `EXPECTED_TT` (16'hE61E) -> `tt` = 16'hAAAA, `match` = 0, `fail_idx` = 2.
- Stub `y0 = 0`, default `EXPECTED_TT` -> `tt` = 16'h0000, `fail_idx` = 1. Also check `x` walks 0..15, each value held exactly 2 cycles.
- SETTLE = 3, stub `y0 = x3` -> `done` at +64 edges, `tt` = 16'hFF00. Also check a `start` pulse at cycle 10 of the sweep is ignored.
- Assert `rst` at cycle 17 of a sweep -> all outputs 0 immediately (asynchronously). A new `start` then yields a full 32-cycle sweep with correct `tt`.
- Real `top` netlist instance with default parameters -> `match` = 1, `tt` = 16'hE61E. Then `start` in DONE re-runs and again yields `match` = 1.
